// File: rtl/cdm_serial_mult_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cdm_serial_mult_ctrl_pkg
// Shared types and constants for the row-serial carry-disregard multiplier.
//   state_t        : sequencer states (IDLE, ACCUM, DONE)
//   CDM_N          : default operand width
//   CDM_APPROX     : default number of low carry-disregard columns
//   cdm_exact_ref  : whole-product reference of the approximate multiply
// -----------------------------------------------------------------------------
package cdm_serial_mult_ctrl_pkg;

  localparam int CDM_N      = 8;
  localparam int CDM_W      = 2 * CDM_N;
  localparam int CDM_APPROX = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Folds every enabled row into the accumulator: low columns XOR only,
  // upper columns add with the carry out of the top bit dropped.
  function automatic logic [CDM_W-1:0] cdm_exact_ref(input logic [CDM_N-1:0] a,
                                                     input logic [CDM_N-1:0] b,
                                                     input int approx);
    logic [CDM_W-1:0] acc;
    logic [CDM_W-1:0] pp;
    logic [CDM_W-1:0] mask;
    logic [CDM_W-1:0] sum;
    acc  = '0;
    mask = (approx >= CDM_W) ? '1 : ((CDM_W'(1) << approx) - CDM_W'(1));
    for (int i = 0; i < CDM_N; i++) begin
      pp  = {{CDM_N{1'b0}}, (b[i] ? a : '0)} << i;
      sum = (acc & ~mask) + (pp & ~mask);
      acc = (sum & ~mask) | ((acc ^ pp) & mask);
    end
    return acc;
  endfunction

endpackage

// File: rtl/cdm_serial_mult_ctrl_if.sv
// -----------------------------------------------------------------------------
// cdm_serial_mult_ctrl_if
// Operand/product handshake bundle for cdm_serial_mult_ctrl.
//   in_valid/in_ready/in_a/in_b : operand pair, valid/ready
//   out_valid/out_ready/out_p   : product, valid/ready
//   busy                        : multiplier occupied (ACCUM or DONE)
// master = requester side, slave = multiplier side.
// -----------------------------------------------------------------------------
interface cdm_serial_mult_ctrl_if
  import cdm_serial_mult_ctrl_pkg::*;
#(
  parameter int N = CDM_N
);

  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_a;
  logic [N-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] out_p;
  logic           busy;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p, busy
  );

endinterface

// File: rtl/cdm_serial_mult_ctrl_row_step.sv
// -----------------------------------------------------------------------------
// cdm_serial_mult_ctrl_row_step
// Combinational accumulate step: o_sum = step(i_acc, i_pp).
//   i_acc  : current accumulator (W bits)
//   i_pp   : shifted partial-product row (W bits)
//   o_sum  : next accumulator (W bits)
// Columns below APPROX are pi-cells (XOR, carry killed); columns from APPROX
// up form a ripple chain whose first cell has carry-in 0 (a half adder) and
// the rest are full adders. The carry out of the top column is discarded.
// -----------------------------------------------------------------------------
module cdm_serial_mult_ctrl_row_step #(
  parameter int W      = 16,
  parameter int APPROX = 6
) (
  input  logic [W-1:0] i_acc,
  input  logic [W-1:0] i_pp,
  output logic [W-1:0] o_sum
);

  logic w_cy;

  always_comb begin
    o_sum = '0;
    w_cy  = 1'b0;
    for (int k = 0; k < W; k++) begin
      if (k < APPROX) begin
        o_sum[k] = i_acc[k] ^ i_pp[k];
      end else begin
        o_sum[k] = i_acc[k] ^ i_pp[k] ^ w_cy;
        w_cy     = (i_acc[k] & i_pp[k]) | (w_cy & (i_acc[k] ^ i_pp[k]));
      end
    end
  end

endmodule

// File: rtl/cdm_serial_mult_ctrl.sv
// -----------------------------------------------------------------------------
// cdm_serial_mult_ctrl
// Row-serial carry-disregard approximate multiplier. One partial-product row
// is retired per cycle through a single shared row_step adder.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, discards any operation in flight
//   bus    : cdm_serial_mult_ctrl_if.slave (operand in, product out, busy)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | in_ready=1, waiting for an operand pair
// ST_ACCUM | one row per cycle, rows 0..N-1, busy=1
// ST_DONE  | out_valid=1, out_p held until out_ready
// -----------------------------------------------------------------------------
module cdm_serial_mult_ctrl
  import cdm_serial_mult_ctrl_pkg::*;
#(
  parameter int N      = CDM_N,
  parameter int APPROX = CDM_APPROX
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cdm_serial_mult_ctrl_if.slave bus
);

  localparam int W  = 2 * N;
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(N - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  state_t         r_state;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [RW-1:0]  r_row;
  logic [W-1:0]   r_acc;
  logic           r_in_ready;
  logic           r_out_valid;
  logic           r_busy;

  logic [W-1:0]   w_pp;
  logic [W-1:0]   w_step;

  // Disabled rows produce an all-zero pp, so every row still costs one cycle.
  assign w_pp = {{N{1'b0}}, (r_a & {N{r_b[r_row]}})} << r_row;

  cdm_serial_mult_ctrl_row_step #(
    .W      (W),
    .APPROX (APPROX)
  ) u_row_step (
    .i_acc (r_acc),
    .i_pp  (w_pp),
    .o_sum (w_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_row       <= '0;
      r_acc       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_a        <= bus.in_a;
            r_b        <= bus.in_b;
            r_acc      <= '0;
            r_row      <= '0;
            r_state    <= ST_ACCUM;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        ST_ACCUM: begin
          r_acc <= w_step;
          if (r_row == ROW_LAST) begin
            // Park the counter at 0 rather than letting it wrap.
            r_row       <= '0;
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_row <= r_row + ROW_ONE;
          end
        end
        ST_DONE: begin
          // in_ready rises on the edge that leaves DONE, so a new pair can
          // only be taken on the following edge.
          if (bus.out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_p     = r_acc;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_cdm_serial_mult_ctrl.sv
module tb_cdm_serial_mult_ctrl;
  import cdm_serial_mult_ctrl_pkg::*;

  localparam int N     = 8;
  localparam int NRAND = 12;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  cdm_serial_mult_ctrl_if #(.N(N)) if6 ();
  cdm_serial_mult_ctrl_if #(.N(N)) if0 ();

  cdm_serial_mult_ctrl #(.N(N), .APPROX(6)) u_dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if6)
  );

  cdm_serial_mult_ctrl #(.N(N), .APPROX(0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference: low columns XOR, high columns add modulo 2^(2N-approx).
  function automatic int unsigned ref_mult(input int unsigned a, input int unsigned b,
                                           input int approx);
    int unsigned acc, pp, lo, hi, lo_mask, hi_mod;
    lo_mask = (32'd1 << approx) - 32'd1;
    hi_mod  = 32'd1 << (2 * N - approx);
    acc     = 0;
    for (int i = 0; i < N; i++) begin
      if (((b >> i) & 32'd1) != 0) begin
        pp  = a << i;
        lo  = (acc ^ pp) & lo_mask;
        hi  = ((acc >> approx) + (pp >> approx)) % hi_mod;
        acc = (hi << approx) | lo;
      end
    end
    return acc;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic f_in_ready(input int sel);
    return (sel == 0) ? if6.in_ready : if0.in_ready;
  endfunction
  function automatic logic f_out_valid(input int sel);
    return (sel == 0) ? if6.out_valid : if0.out_valid;
  endfunction
  function automatic logic [2*N-1:0] f_out_p(input int sel);
    return (sel == 0) ? if6.out_p : if0.out_p;
  endfunction
  function automatic logic f_busy(input int sel);
    return (sel == 0) ? if6.busy : if0.busy;
  endfunction

  task automatic drv_in(input int sel, input logic v, input logic [N-1:0] a, input logic [N-1:0] b);
    if (sel == 0) begin
      if6.in_valid = v; if6.in_a = a; if6.in_b = b;
    end else begin
      if0.in_valid = v; if0.in_a = a; if0.in_b = b;
    end
  endtask

  task automatic drv_ordy(input int sel, input logic r);
    if (sel == 0) if6.out_ready = r;
    else          if0.out_ready = r;
  endtask

  task automatic start_op(input int sel, input logic [N-1:0] a, input logic [N-1:0] b,
                          input string tag, output int t_acc);
    @(negedge clk);
    drv_in(sel, 1'b1, a, b);
    chk({tag, ".in_ready"}, 32'(f_in_ready(sel)), 32'd1);
    @(negedge clk);
    drv_in(sel, 1'b0, '0, '0);
    t_acc = cyc;
  endtask

  task automatic wait_done(input int sel, input logic [2*N-1:0] exp_p, input int t_acc,
                           input string tag);
    int guard;
    guard = 0;
    while (f_out_valid(sel) !== 1'b1 && guard < 4 * N) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, ".done_seen"}, 32'(guard < 4 * N), 32'd1);
    chk({tag, ".latency"}, 32'(cyc - t_acc), 32'(N));
    chk({tag, ".out_p"}, 32'(f_out_p(sel)), 32'(exp_p));
    chk({tag, ".busy"}, 32'(f_busy(sel)), 32'd1);
  endtask

  task automatic retire(input int sel, input string tag);
    drv_ordy(sel, 1'b1);
    @(negedge clk);
    drv_ordy(sel, 1'b0);
    chk({tag, ".valid_drop"}, 32'(f_out_valid(sel)), 32'd0);
    chk({tag, ".ready_back"}, 32'(f_in_ready(sel)), 32'd1);
    chk({tag, ".busy_drop"}, 32'(f_busy(sel)), 32'd0);
  endtask

  task automatic do_op(input int sel, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [2*N-1:0] exp_p, input string tag);
    int t;
    start_op(sel, a, b, tag, t);
    wait_done(sel, exp_p, t, tag);
    retire(sel, tag);
  endtask

  logic [N-1:0]   ra, rb;
  logic [2*N-1:0] e;
  logic [2*N-1:0] q[$];
  int             t_op;
  int             nacc, ndone, last, guard;

  initial begin
    rst_n = 1'b0;
    drv_in(0, 1'b0, '0, '0);
    drv_in(1, 1'b0, '0, '0);
    drv_ordy(0, 1'b0);
    drv_ordy(1, 1'b0);
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst.in_ready", 32'(f_in_ready(s)), 32'd1);
      chk("rst.out_valid", 32'(f_out_valid(s)), 32'd0);
      chk("rst.busy", 32'(f_busy(s)), 32'd0);
      chk("rst.out_p", 32'(f_out_p(s)), 32'd0);
    end
    rst_n = 1'b1;

    // Directed: approximate and exact corner products.
    do_op(0, 8'd3, 8'd3, 16'd5, "t1_3x3_ax6");
    do_op(0, 8'd128, 8'd128, 16'd16384, "t2_128x128_ax6");
    do_op(1, 8'd255, 8'd255, 16'd65025, "t3_255x255_ex");
    do_op(1, 8'd255, 8'd1, 16'd255, "t3_255x1_ex");
    do_op(1, 8'd0, 8'd200, 16'd0, "t3_0x200_ex");
    do_op(0, 8'd0, 8'd0, 16'd0, "t3_0x0_ax6");

    // Stall in DONE with in_valid pulses that must be ignored.
    ra = 8'($urandom);
    rb = 8'($urandom) | 8'h81;
    e  = 16'(ref_mult(ra, rb, 6));
    start_op(0, ra, rb, "t4", t_op);
    wait_done(0, e, t_op, "t4");
    for (int i = 0; i < 5; i++) begin
      drv_in(0, (i % 2) == 0, 8'($urandom), 8'($urandom));
      @(negedge clk);
      chk("t4.hold_valid", 32'(if6.out_valid), 32'd1);
      chk("t4.hold_p", 32'(if6.out_p), 32'(e));
      chk("t4.hold_in_ready", 32'(if6.in_ready), 32'd0);
    end
    drv_in(0, 1'b0, '0, '0);
    retire(0, "t4");
    ra = 8'($urandom);
    rb = 8'($urandom);
    do_op(0, ra, rb, 16'(ref_mult(ra, rb, 6)), "t4_after");

    // Reset at row 4 of ACCUM.
    start_op(0, 8'd77, 8'd201, "t5", t_op);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5.rst_out_valid", 32'(if6.out_valid), 32'd0);
    chk("t5.rst_in_ready", 32'(if6.in_ready), 32'd1);
    chk("t5.rst_busy", 32'(if6.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 2) @(negedge clk);
    chk("t5.no_output", 32'(if6.out_valid), 32'd0);
    do_op(0, 8'd2, 8'd3, 16'd6, "t5_next_2x3");

    // Back-to-back random pairs with out_ready held high.
    nacc  = 0;
    ndone = 0;
    last  = -1;
    guard = 0;
    drv_ordy(0, 1'b1);
    while (ndone < NRAND && guard < NRAND * (N + 2) + 50) begin
      @(negedge clk);
      guard++;
      if (if6.out_valid === 1'b1) begin
        if (q.size() == 0) begin
          chk("t6.queue_depth", 32'(q.size()), 32'd1);
        end else begin
          e = q.pop_front();
          chk("t6.out_p", 32'(if6.out_p), 32'(e));
        end
        ndone++;
      end
      if (if6.in_ready === 1'b1 && nacc < NRAND) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        drv_in(0, 1'b1, ra, rb);
        q.push_back(16'(ref_mult(ra, rb, 6)));
        if (last >= 0) chk("t6.spacing", 32'(cyc - last), 32'(N + 2));
        last = cyc;
        nacc++;
      end else begin
        drv_in(0, 1'b0, '0, '0);
      end
    end
    drv_ordy(0, 1'b0);
    drv_in(0, 1'b0, '0, '0);
    chk("t6.count", 32'(ndone), 32'(NRAND));

    // Random exact-mode products against plain multiplication.
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      do_op(1, ra, rb, {8'b0, ra} * {8'b0, rb}, "t6_exact");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
